// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl: runtime-programmable tick generator that drives the clock-division datapath.
//
// Takes a divisor and tick-count target over a valid/ready handshake, then runs a single cycle
// counter under start/pause/resume/stop commands.
//
// Ports
//   clk_in     system clock
//   rst_n      asynchronous active-low reset
//   cfg_valid  configuration offer
//   cfg_ready  configuration accepted when high together with cfg_valid (high in IDLE only)
//   cfg_div    clk_in cycles per tick (values below 2 clamp to 2)
//   cfg_ticks  ticks to emit before done; 0 selects free-running
//   start      begin a run (honoured in IDLE only)
//   pause      freeze the run
//   resume     continue a paused run
//   stop       abort to IDLE
//   tick       one-cycle clock-enable pulse
//   sq_out     square wave that toggles on every tick
//   tick_cnt   ticks emitted in the current run
//   done       one-cycle pulse, the cycle after the final tick
//   busy       high in RUN or PAUSE
module tick_sched_ctrl #(
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned TICKS_W     = 16,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [TICKS_W-1:0] cfg_ticks,
    input  logic               start,
    input  logic               pause,
    input  logic               resume,
    input  logic               stop,
    output logic               tick,
    output logic               sq_out,
    output logic [TICKS_W-1:0] tick_cnt,
    output logic               done,
    output logic               busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     div_q, div_d;
    logic [TICKS_W-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 tick_q, tick_d;
    logic                 sq_q, sq_d;
    logic [TICKS_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 terminal;
    logic [TICKS_W-1:0]   tick_cnt_inc;

    assign cfg_ready    = (state_q == StIdle);
    assign terminal     = (count_q == div_q - CNT_W'(1));
    assign tick_cnt_inc = tick_cnt_q + TICKS_W'(1);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tgt_d      = tgt_q;
        count_d    = count_q;
        tick_d     = 1'b0;
        sq_d       = sq_q;
        tick_cnt_d = tick_cnt_q;

        // Config lands in the same edge as a start, so the new values govern that run.
        if (cfg_valid && cfg_ready) begin
            div_d = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
            tgt_d = cfg_ticks;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    count_d    = '0;
                    tick_cnt_d = '0;
                    sq_d       = 1'b0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    count_d = '0;
                    sq_d    = 1'b0;
                end else if (pause) begin
                    // Count is held as-is so the remaining distance to the next tick survives.
                    state_d = StPause;
                end else if (terminal) begin
                    count_d    = '0;
                    tick_d     = 1'b1;
                    sq_d       = ~sq_q;
                    tick_cnt_d = tick_cnt_inc;
                    if ((tgt_q != '0) && (tick_cnt_inc == tgt_q)) begin
                        state_d = StDone;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            StPause: begin
                if (stop) begin
                    state_d = StIdle;
                    count_d = '0;
                    sq_d    = 1'b0;
                end else if (!pause && resume) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // done trails the DONE state by one edge so it never coincides with the final tick.
        done_d = (state_q == StDone);
        busy_d = (state_d == StRun) || (state_d == StPause);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            div_q      <= CNT_W'(DEFAULT_DIV);
            tgt_q      <= '0;
            count_q    <= '0;
            tick_q     <= 1'b0;
            sq_q       <= 1'b0;
            tick_cnt_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tgt_q      <= tgt_d;
            count_q    <= count_d;
            tick_q     <= tick_d;
            sq_q       <= sq_d;
            tick_cnt_q <= tick_cnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign tick     = tick_q;
    assign sq_out   = sq_q;
    assign tick_cnt = tick_cnt_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Directed bench for tick_sched_ctrl. Inputs change and outputs are sampled on the falling
// edge. "Cycle k" is the interval after the k-th rising edge following the start edge.
module tb_tick_sched_ctrl;

    localparam int unsigned CNT_W   = 26;
    localparam int unsigned TICKS_W = 16;

    logic               clk_in;
    logic               rst_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_div;
    logic [TICKS_W-1:0] cfg_ticks;
    logic               start;
    logic               pause;
    logic               resume;
    logic               stop;
    logic               tick;
    logic               sq_out;
    logic [TICKS_W-1:0] tick_cnt;
    logic               done;
    logic               busy;

    int n_checks;
    int n_fails;

    tick_sched_ctrl #(
        .CNT_W      (CNT_W),
        .TICKS_W    (TICKS_W),
        .DEFAULT_DIV(4)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .cfg_ticks(cfg_ticks),
        .start    (start),
        .pause    (pause),
        .resume   (resume),
        .stop     (stop),
        .tick     (tick),
        .sq_out   (sq_out),
        .tick_cnt (tick_cnt),
        .done     (done),
        .busy     (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Load a configuration for one edge while IDLE.
    task automatic configure(input int div, input int ticks);
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(div);
        cfg_ticks = TICKS_W'(ticks);
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    // Pulse start; on return the bench sits in cycle 0.
    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_ticks = '0;
        start     = 1'b0;
        pause     = 1'b0;
        resume    = 1'b0;
        stop      = 1'b0;

        // Reset values
        cyc(2);
        check_eq("rst_tick", 32'(tick), 0);
        check_eq("rst_sq", 32'(sq_out), 0);
        check_eq("rst_tick_cnt", 32'(tick_cnt), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_cfg_ready", 32'(cfg_ready), 1);
        rst_n = 1'b1;
        cyc(1);

        // Default divisor 4, free-running: ticks at 4, 8, 12
        do_start();
        for (int c = 1; c <= 13; c++) begin
            cyc(1);
            check_eq("def_tick", 32'(tick), (c % 4 == 0) ? 1 : 0);
            check_eq("def_sq", 32'(sq_out), (c / 4) % 2);
            check_eq("def_tick_cnt", 32'(tick_cnt), c / 4);
        end
        check_eq("def_busy", 32'(busy), 1);
        check_eq("def_cfg_ready", 32'(cfg_ready), 0);
        do_stop();
        check_eq("def_stop_busy", 32'(busy), 0);
        check_eq("def_stop_sq", 32'(sq_out), 0);
        check_eq("def_stop_cnt", 32'(tick_cnt), 3);

        // div=3, ticks=2: ticks at 3 and 6, done at 7
        configure(3, 2);
        do_start();
        for (int c = 1; c <= 8; c++) begin
            cyc(1);
            check_eq("tgt_tick", 32'(tick), (c == 3 || c == 6) ? 1 : 0);
            check_eq("tgt_done", 32'(done), (c == 7) ? 1 : 0);
            if (c == 5) check_eq("tgt_busy_run", 32'(busy), 1);
        end
        check_eq("tgt_tick_cnt", 32'(tick_cnt), 2);
        check_eq("tgt_busy_end", 32'(busy), 0);
        check_eq("tgt_cfg_ready", 32'(cfg_ready), 1);

        // div=5: pause with count=2 for 10 edges, resume; remaining 3 RUN edges preserved
        configure(5, 0);
        do_start();
        cyc(2);
        pause = 1'b1;
        for (int c = 3; c <= 12; c++) begin
            cyc(1);
            check_eq("pause_tick", 32'(tick), 0);
        end
        check_eq("pause_busy", 32'(busy), 1);
        pause  = 1'b0;
        resume = 1'b1;
        cyc(1);
        resume = 1'b0;
        for (int c = 14; c <= 21; c++) begin
            cyc(1);
            check_eq("resume_tick", 32'(tick), (c == 16 || c == 21) ? 1 : 0);
        end
        check_eq("resume_cnt", 32'(tick_cnt), 2);
        do_stop();

        // div=4: pause on the terminal-count edge, tick on first RUN edge after resume
        configure(4, 0);
        do_start();
        cyc(3);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        check_eq("tc_pause_tick", 32'(tick), 0);
        resume = 1'b1;
        cyc(1);
        resume = 1'b0;
        check_eq("tc_resume_edge_tick", 32'(tick), 0);
        cyc(1);
        check_eq("tc_first_run_tick", 32'(tick), 1);
        check_eq("tc_tick_cnt", 32'(tick_cnt), 1);
        do_stop();

        // div=3, ticks=3: stop on the 3rd tick edge beats the tick
        configure(3, 3);
        do_start();
        cyc(8);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check_eq("stop_tick", 32'(tick), 0);
        check_eq("stop_busy", 32'(busy), 0);
        check_eq("stop_sq", 32'(sq_out), 0);
        check_eq("stop_tick_cnt", 32'(tick_cnt), 2);
        check_eq("stop_cfg_ready", 32'(cfg_ready), 1);
        cyc(1);
        check_eq("stop_no_done", 32'(done), 0);

        // cfg_div=0 clamps to 2; config during RUN is refused
        configure(0, 0);
        do_start();
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) begin
                cfg_valid = 1'b1;
                cfg_div   = CNT_W'(7);
                #1;
                check_eq("run_cfg_ready", 32'(cfg_ready), 0);
            end
            cyc(1);
            check_eq("clamp_tick", 32'(tick), (c % 2 == 0) ? 1 : 0);
        end
        cfg_valid = 1'b0;
        cyc(1);
        check_eq("clamp_tick_after_cfg", 32'(tick), 0);
        cyc(1);
        check_eq("clamp_div_unchanged", 32'(tick), 1);
        check_eq("clamp_sq", 32'(sq_out), 0);
        cyc(1);
        cyc(1);
        check_eq("pre_rst_sq", 32'(sq_out), 1);

        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_tick", 32'(tick), 0);
        check_eq("arst_sq", 32'(sq_out), 0);
        check_eq("arst_tick_cnt", 32'(tick_cnt), 0);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_done", 32'(done), 0);
        check_eq("arst_cfg_ready", 32'(cfg_ready), 1);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // Divisor back to default 4
        do_start();
        for (int c = 1; c <= 4; c++) begin
            cyc(1);
            check_eq("post_rst_tick", 32'(tick), (c == 4) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
